timer_input_capture: RTL and testbench

//  Input-capture channel for the Timer_1 peripheral; it is the receive side of the output-compare toggle path.

---
 rtl/timer_input_capture_pkg.sv | 38 +++
 rtl/timer_input_capture_if.sv | 28 ++
 rtl/timer_input_capture_sync_filter.sv | 59 +++++
 rtl/timer_input_capture.sv | 112 +++++++++++
 tb/tb_timer_input_capture.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_input_capture_pkg.sv
// Shared encodings for the Timer_1 input-capture channel.
//   edge_sel_e : which pin transitions qualify (none / rising / falling / both)
//   psc_sel_e  : capture on every 1st / 2nd / 4th / 8th qualifying edge
//   psc_last() : terminal prescaler count (N-1) for a prescaler encoding
//   SYNC_SETTLE: cycles the pin pipeline needs before edges can be trusted
package timer_input_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        PSC_DIV1 = 2'b00,
        PSC_DIV2 = 2'b01,
        PSC_DIV4 = 2'b10,
        PSC_DIV8 = 2'b11
    } psc_sel_e;

    // sync1 -> sync2 -> prev: three edges before prev agrees with the pin
    localparam int SYNC_SETTLE = 3;

    function automatic logic [2:0] psc_last(input logic [1:0] sel);
        logic [2:0] last;
        last = 3'd0;
        case (sel)
            PSC_DIV1: last = 3'd0;
            PSC_DIV2: last = 3'd1;
            PSC_DIV4: last = 3'd3;
            PSC_DIV8: last = 3'd7;
            default:  last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/timer_input_capture_if.sv
// Bus bundle between the timer core (master) and the input-capture channel (slave).
//   en, i_signal, i_counter, i_edge_sel, i_psc_sel, i_flag_clr, i_irq_en : master -> channel
//   o_capture, o_capture_flag, o_overcapture, o_irq                       : channel -> master
interface timer_input_capture_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             i_signal;
    logic [WIDTH-1:0] i_counter;
    logic [1:0]       i_edge_sel;
    logic [1:0]       i_psc_sel;
    logic             i_flag_clr;
    logic             i_irq_en;
    logic [WIDTH-1:0] o_capture;
    logic             o_capture_flag;
    logic             o_overcapture;
    logic             o_irq;

    modport master (
        output en, i_signal, i_counter, i_edge_sel, i_psc_sel, i_flag_clr, i_irq_en,
        input  o_capture, o_capture_flag, o_overcapture, o_irq
    );

    modport slave (
        input  en, i_signal, i_counter, i_edge_sel, i_psc_sel, i_flag_clr, i_irq_en,
        output o_capture, o_capture_flag, o_overcapture, o_irq
    );
endinterface

// File: rtl/timer_input_capture_sync_filter.sv
// ic_sync_filter: two-flop synchroniser for the asynchronous capture pin, with an
// optional glitch filter enabled by the IC_INPUT_FILTER_EN macro.
//   clk, rst : peripheral clock, async active-high reset
//   i_signal : raw external pin
//   o_f      : synchronised (and, if enabled, filtered) pin level
module ic_sync_filter
`ifdef IC_INPUT_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_signal,
    output logic o_f
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_signal;
            sync2_q <= sync1_q;
        end
    end

`ifdef IC_INPUT_FILTER_EN
    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

    logic       f_q;
    logic [3:0] flt_cnt_q;

    // The output level only follows sync2 once it has disagreed for FILTER_LEN
    // consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= 1'b0;
            flt_cnt_q <= 4'd0;
        end else if (sync2_q == f_q) begin
            flt_cnt_q <= 4'd0;
        end else if (flt_cnt_q == FLT_LAST) begin
            f_q       <= sync2_q;
            flt_cnt_q <= 4'd0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 4'd1;
        end
    end

    assign o_f = f_q;
`else
    assign o_f = sync2_q;
`endif

endmodule

// File: rtl/timer_input_capture.sv
// timer_input_capture: Timer_1 input-capture channel. Detects the selected pin edge,
// prescales qualifying edges and latches the shared timer count on every Nth one.
//   clk, rst : peripheral clock, async active-high reset
//   bus      : timer_input_capture_if.slave (enable, pin, counter, edge/prescaler
//              select, flag clear, irq enable in; capture value, flag, overcapture, irq out)
// Optional feature: IC_INPUT_FILTER_EN adds a FILTER_LEN-cycle glitch filter on the pin.
module timer_input_capture
    import timer_input_capture_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    timer_input_capture_if.slave   bus
);

`ifdef IC_INPUT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    // With the filter the pin pipeline is FILTER_LEN cycles deeper, so arming waits
    // that much longer; otherwise a pin held high at reset release would still look
    // like a rising edge once it finally emerges from the filter.
    localparam logic [4:0] SETTLE = 5'(SYNC_SETTLE + (FILTER_EN ? FILTER_LEN : 0));

    logic             f;
    logic             prev_q;
    logic [4:0]       settle_q, settle_d;
    logic [2:0]       psc_q, psc_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic             flag_q, flag_d;
    logic             ovc_q, ovc_d;
    logic             armed, rise, fall, edge_hit, capture;

`ifdef IC_INPUT_FILTER_EN
    ic_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
`else
    ic_sync_filter u_sync_filter (
`endif
        .clk      (clk),
        .rst      (rst),
        .i_signal (bus.i_signal),
        .o_f      (f)
    );

    assign armed    = (settle_q == SETTLE);
    assign rise     = f & ~prev_q;
    assign fall     = ~f & prev_q;
    assign edge_hit = armed & bus.en &
                      ((bus.i_edge_sel[0] & rise) | (bus.i_edge_sel[1] & fall));
    // ">=" so that lowering the prescaler below the current count captures on the next edge
    assign capture  = edge_hit & (psc_q >= psc_last(bus.i_psc_sel));

    always_comb begin
        settle_d  = settle_q;
        psc_d     = psc_q;
        capture_d = capture_q;
        flag_d    = flag_q;
        ovc_d     = ovc_q;

        if (!bus.en) begin
            settle_d = 5'd0;
            psc_d    = 3'd0;
        end else begin
            if (!armed) begin
                settle_d = settle_q + 5'd1;
            end
            if (edge_hit) begin
                psc_d = capture ? 3'd0 : psc_q + 3'd1;
            end
        end

        if (bus.i_flag_clr) begin
            flag_d = 1'b0;
            ovc_d  = 1'b0;
        end
        // A capture coinciding with a clear leaves a fresh flag but no overcapture
        if (capture) begin
            capture_d = bus.i_counter;
            flag_d    = 1'b1;
            if (flag_q && !bus.i_flag_clr) begin
                ovc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= 1'b0;
            settle_q  <= 5'd0;
            psc_q     <= 3'd0;
            capture_q <= '0;
            flag_q    <= 1'b0;
            ovc_q     <= 1'b0;
        end else begin
            prev_q    <= f;
            settle_q  <= settle_d;
            psc_q     <= psc_d;
            capture_q <= capture_d;
            flag_q    <= flag_d;
            ovc_q     <= ovc_d;
        end
    end

    assign bus.o_capture      = capture_q;
    assign bus.o_capture_flag = flag_q;
    assign bus.o_overcapture  = ovc_q;
    assign bus.o_irq          = flag_q & bus.i_irq_en;

endmodule

// File: tb/tb_timer_input_capture.sv
// Directed bench for timer_input_capture; honours IC_INPUT_FILTER_EN when defined.
module tb_timer_input_capture;

`ifdef IC_INPUT_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif
    // pin change to capture edge
    localparam int LAT = 3 + FLT;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    logic [15:0] ctr_base;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_input_capture_if #(.WIDTH(16)) bus ();
    assign bus.i_counter = ctr_base + 16'(cyc);

    timer_input_capture #(.WIDTH(16), .FILTER_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.i_flag_clr = 1'b1;
        step(1);
        bus.i_flag_clr = 1'b0;
    endtask

    // counter value sampled at the most recent rising edge
    function automatic logic [15:0] ctr_last();
        return ctr_base + 16'(cyc) - 16'd1;
    endfunction

    logic [15:0] exp_cap;

    initial begin
        ctr_base       = 16'h0000;
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.i_signal   = 1'b0;
        bus.i_edge_sel = 2'b01;
        bus.i_psc_sel  = 2'b00;
        bus.i_flag_clr = 1'b0;
        bus.i_irq_en   = 1'b1;
        step(2);
        chk("rst_capture", bus.o_capture, 0);
        chk("rst_flag", bus.o_capture_flag, 0);
        chk("rst_ovc", bus.o_overcapture, 0);
        chk("rst_irq", bus.o_irq, 0);
        rst = 1'b0;
        step(5 + FLT);

        // rising edge, psc 1, counter = 0x0100 + cycle, pin rises at cycle 10
        ctr_base = 16'h0101 - 16'(cyc);
        step(10);
        bus.i_signal = 1'b1;
        step(LAT - 1);
        chk("t1_flag_early", bus.o_capture_flag, 0);
        step(1);
        chk("t1_capture", bus.o_capture, 16'h010D + 16'(FLT));
        chk("t1_flag", bus.o_capture_flag, 1);
        chk("t1_irq", bus.o_irq, 1);
        chk("t1_ovc", bus.o_overcapture, 0);
        pulse_clr();
        chk("t1_clr_flag", bus.o_capture_flag, 0);
        chk("t1_clr_irq", bus.o_irq, 0);
        bus.i_signal = 1'b0;
        step(LAT + 1);
        chk("fall_in_rise_mode", bus.o_capture_flag, 0);

        // both edges, psc 4: captures on the 4th and 8th toggles only
        bus.i_edge_sel = 2'b11;
        bus.i_psc_sel  = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            bus.i_signal = ~bus.i_signal;
            step(LAT);
            if (i % 4 == 0) begin
                chk("t2_flag_cap", bus.o_capture_flag, 1);
                chk("t2_capture", bus.o_capture, ctr_last());
            end else begin
                chk("t2_flag_none", bus.o_capture_flag, 0);
            end
            pulse_clr();
            step(1);
        end

`ifndef IC_INPUT_FILTER_EN
        // both edges, psc 2, pin toggling every cycle: two captures, none lost
        bus.i_psc_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus.i_signal = ~bus.i_signal;
            step(1);
        end
        step(2);
        chk("toggle_capture", bus.o_capture, ctr_last());
        chk("toggle_flag", bus.o_capture_flag, 1);
        chk("toggle_ovc", bus.o_overcapture, 1);
        pulse_clr();
`endif

        // overcapture, then clear coinciding with a capture
        bus.i_edge_sel = 2'b01;
        bus.i_psc_sel  = 2'b00;
        bus.i_signal = 1'b1;
        step(LAT);
        chk("t3_first_flag", bus.o_capture_flag, 1);
        bus.i_signal = 1'b0;
        step(LAT);
        bus.i_signal = 1'b1;
        step(LAT);
        exp_cap = ctr_last();
        chk("t3_second_capture", bus.o_capture, exp_cap);
        chk("t3_ovc", bus.o_overcapture, 1);
        bus.i_signal = 1'b0;
        step(LAT);
        bus.i_signal = 1'b1;
        step(LAT - 1);
        bus.i_flag_clr = 1'b1;
        step(1);
        bus.i_flag_clr = 1'b0;
        chk("t3_clr_cap_flag", bus.o_capture_flag, 1);
        chk("t3_clr_cap_ovc", bus.o_overcapture, 0);
        chk("t3_clr_cap_value", bus.o_capture, ctr_last());
        pulse_clr();
        chk("t3_clr_flag", bus.o_capture_flag, 0);

        // irq gating
        bus.i_irq_en = 1'b0;
        bus.i_signal = 1'b0;
        step(LAT);
        bus.i_signal = 1'b1;
        step(LAT);
        chk("irq_masked_flag", bus.o_capture_flag, 1);
        chk("irq_masked", bus.o_irq, 0);
        bus.i_irq_en = 1'b1;
        #1;
        chk("irq_unmasked", bus.o_irq, 1);
        pulse_clr();

        // edge select none
        bus.i_edge_sel = 2'b00;
        bus.i_signal = 1'b0;
        step(LAT + 1);
        bus.i_signal = 1'b1;
        step(LAT + 1);
        chk("edge_none", bus.o_capture_flag, 0);
        bus.i_edge_sel = 2'b01;

        // pin high across reset release and across enable
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10 + FLT);
        chk("pin_high_at_reset", bus.o_capture_flag, 0);
        bus.en = 1'b0;
        bus.i_signal = 1'b0;
        step(LAT + 1);
        bus.i_signal = 1'b1;
        step(LAT + 1);
        chk("disabled_no_capture", bus.o_capture_flag, 0);
        bus.en = 1'b1;
        step(10 + FLT);
        chk("pin_high_at_enable", bus.o_capture_flag, 0);
        bus.i_signal = 1'b0;
        step(LAT);
        bus.i_signal = 1'b1;
        step(LAT);
        chk("capture_after_enable", bus.o_capture_flag, 1);
        pulse_clr();

        // reset with prescaler count 2 restarts the count
        bus.i_psc_sel = 2'b10;
        bus.i_signal = 1'b0;
        step(LAT);
        for (int i = 0; i < 2; i++) begin
            bus.i_signal = 1'b1;
            step(LAT);
            bus.i_signal = 1'b0;
            step(LAT);
        end
        chk("t6_pre_rst_flag", bus.o_capture_flag, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_rst_capture", bus.o_capture, 0);
        step(2);
        rst = 1'b0;
        step(5 + FLT);
        for (int k = 1; k <= 4; k++) begin
            bus.i_signal = 1'b1;
            step(LAT);
            chk("t6_rise_flag", bus.o_capture_flag, (k == 4) ? 1 : 0);
            bus.i_signal = 1'b0;
            step(LAT);
        end
        pulse_clr();

        // short pulse: filtered out only when the filter is present
        bus.i_psc_sel = 2'b00;
        bus.i_signal = 1'b1;
        step(3);
        bus.i_signal = 1'b0;
`ifdef IC_INPUT_FILTER_EN
        step(10);
        chk("t5_3cyc_filtered", bus.o_capture_flag, 0);
        bus.i_signal = 1'b1;
        step(5);
        bus.i_signal = 1'b0;
        step(1);
        chk("t5_5cyc_early", bus.o_capture_flag, 0);
        step(1);
        chk("t5_5cyc_flag", bus.o_capture_flag, 1);
        chk("t5_5cyc_capture", bus.o_capture, ctr_last());
`else
        chk("t5_3cyc_flag", bus.o_capture_flag, 1);
        chk("t5_3cyc_capture", bus.o_capture, ctr_last());
`endif
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
